// File: rtl/serial_merge_sink.sv
// serial_merge_sink
//   Terminal consumer of the serial merge tree. It does the last 2-way
//   compare/select and drives the consume select back to the last merge
//   stage. The merged stream is packed into PACK-element words, and the words
//   are buffered in a first-word-fall-through FIFO toward the host write path.
//   The tree cannot be stalled, so lost data and lost starts are reported
//   through sticky error flags.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   inA, inB        stream heads from the last merge stage (all-ones = exhausted)
//   start_in        one-cycle sequence start pulse from the last stage
//   ctrl_addr_out   consume select (0 = A consumed, 1 = B consumed)
//   out_data        FIFO head word, element 0 in the LSBs
//   out_valid       FIFO non-empty
//   out_ready       host accepts the head word
//   out_last        head word closes a sequence
//   busy            sequencer not idle
//   sort_err        sticky: descending pair seen inside a sequence
//   ovf_err         sticky: word dropped on a full FIFO, or a start pulse lost
module serial_merge_sink #(
  parameter int DATA_WIDTH = 32,
  parameter int SEQ_SIZE   = 16,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int START_LAT  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      inA,
  input  logic [DATA_WIDTH-1:0]      inB,
  input  logic                       start_in,
  output logic                       ctrl_addr_out,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       sort_err,
  output logic                       ovf_err
);

  localparam int ECW = (SEQ_SIZE > 1) ? $clog2(SEQ_SIZE) : 1;
  localparam int LCW = (START_LAT > 1) ? $clog2(START_LAT) : 1;
  localparam int LNW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int WW  = DATA_WIDTH * PACK;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_pending;
  logic                  w_pend_next;
  logic                  w_drop;
  logic                  w_last_elem;
  logic                  w_lat_done;
  logic                  w_stream;
  logic [LCW-1:0]        r_lat_cnt;
  logic [ECW-1:0]        r_elem_cnt;
  logic [LNW-1:0]        r_lane;
  logic [DATA_WIDTH-1:0] w_sel;
  logic [DATA_WIDTH-1:0] r_prev;
  logic [DATA_WIDTH-1:0] r_pack [PACK];
  logic [WW-1:0]         w_pack_word;
  logic                  r_word_vld;
  logic                  r_word_last;
  logic [WW-1:0]         r_mem [FIFO_DEPTH];
  logic                  r_mem_last [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  r_sort_err;
  logic                  r_ovf_err;

  // Final compare/select; the select is only meaningful while streaming.
  assign w_stream      = (r_state == S_STREAM);
  assign ctrl_addr_out = w_stream && (inA > inB);
  assign w_sel         = ctrl_addr_out ? inB : inA;

  assign w_last_elem = w_stream && (r_elem_cnt == ECW'(SEQ_SIZE - 1));
  assign w_lat_done  = (r_lat_cnt == LCW'(START_LAT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pend_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pend_next  = r_pending;
    w_drop       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_in) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (start_in) begin
          if (r_pending) w_drop = 1'b1;
          else           w_pend_next = 1'b1;
        end
        if (w_lat_done) w_state_next = S_STREAM;
      end
      S_STREAM: begin
        if (w_last_elem && !r_pending) begin
          // A start coinciding with the return to idle is served as an idle start.
          w_state_next = start_in ? S_WAIT : S_IDLE;
        end else begin
          if (start_in) begin
            if (r_pending) w_drop = 1'b1;
            else           w_pend_next = 1'b1;
          end
          if (w_last_elem) begin
            w_pend_next  = 1'b0;
            w_state_next = S_WAIT;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Counters idle at zero outside their state, so every entry starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat_cnt  <= '0;
      r_elem_cnt <= '0;
      r_lane     <= '0;
    end else begin
      r_lat_cnt  <= (r_state == S_WAIT) ? r_lat_cnt + 1'b1 : '0;
      if (w_stream) begin
        r_elem_cnt <= w_last_elem ? '0 : r_elem_cnt + 1'b1;
        r_lane     <= (r_lane == LNW'(PACK - 1)) ? '0 : r_lane + 1'b1;
      end else begin
        r_elem_cnt <= '0;
        r_lane     <= '0;
      end
    end
  end

  // Pack register; the completed word is pushed on the following edge, when
  // lane 0 of the next word may already be overwriting r_pack[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PACK; i++) r_pack[i] <= '0;
      r_word_vld  <= 1'b0;
      r_word_last <= 1'b0;
    end else begin
      for (int i = 0; i < PACK; i++) begin
        if (w_stream && (r_lane == LNW'(i))) r_pack[i] <= w_sel;
      end
      r_word_vld  <= w_stream && (r_lane == LNW'(PACK - 1));
      r_word_last <= w_last_elem;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PACK; gi++) begin : g_word
      assign w_pack_word[gi*DATA_WIDTH +: DATA_WIDTH] = r_pack[gi];
    end
  endgenerate

  // Output FIFO. A push into a full FIFO still lands when the head is popped
  // in the same cycle, because the write slot is the one being vacated.
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_pop   = out_valid && out_ready;
  assign w_push  = r_word_vld && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]      <= w_pack_word;
      r_mem_last[r_wr_ptr] <= r_word_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Fall-through read; the word is masked while empty so stale RAM never shows.
  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign out_last  = out_valid && r_mem_last[r_rd_ptr];

  // Sticky error flags; the first element of a sequence has no predecessor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev     <= '0;
      r_sort_err <= 1'b0;
      r_ovf_err  <= 1'b0;
    end else begin
      if (w_stream) begin
        r_prev <= w_sel;
        if ((r_elem_cnt != '0) && (w_sel < r_prev)) r_sort_err <= 1'b1;
      end
      if (w_drop || (r_word_vld && w_full && !w_pop)) r_ovf_err <= 1'b1;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign sort_err = r_sort_err;
  assign ovf_err  = r_ovf_err;

endmodule

// File: tb/tb_serial_merge_sink.sv
module tb_serial_merge_sink;

  localparam int DW = 32;
  localparam int SQ = 16;
  localparam int PK = 4;
  localparam int FD = 8;
  localparam int SL = 2;
  localparam int WW = DW * PK;

  logic          clk;
  logic          rst;
  logic [DW-1:0] inA;
  logic [DW-1:0] inB;
  logic          start_in;
  logic          ctrl_addr_out;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          sort_err;
  logic          ovf_err;

  serial_merge_sink #(
    .DATA_WIDTH(DW), .SEQ_SIZE(SQ), .PACK(PK), .FIFO_DEPTH(FD), .START_LAT(SL)
  ) dut (
    .clk(clk), .rst(rst), .inA(inA), .inB(inB), .start_in(start_in),
    .ctrl_addr_out(ctrl_addr_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .sort_err(sort_err), .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] a_arr [8];
  logic [DW-1:0] b_arr [8];
  logic [WW:0]   got_q [$];
  logic [15:0]   ctrl_seen;
  logic [16:0]   serr_seen;
  logic [16:0]   ovf_seen;

  // Popped words are recorded just before the edge that pops them.
  always @(negedge clk) begin
    #4;
    if (!rst && out_valid && out_ready) got_q.push_back({out_last, out_data});
  end

  function automatic logic [WW-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
  endfunction

  task automatic set_interleave(input int off);
    for (int i = 0; i < 8; i++) begin
      a_arr[i] = DW'(off + 2*i + 1);
      b_arr[i] = DW'(off + 2*i + 2);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start_in = 1'b1;
    inA = a_arr[0];
    inB = b_arr[0];
    @(negedge clk);
    start_in = 1'b0;
    repeat (SL) @(negedge clk);
  endtask

  // Models the last merge stage: each stream advances when the DUT consumes it.
  task automatic do_stream(input int n, input logic [15:0] start_mask,
                           output logic [15:0] c_seen, output logic [16:0] s_seen,
                           output logic [16:0] o_seen);
    int ia;
    int ib;
    ia = 0;
    ib = 0;
    c_seen = '0;
    s_seen = '0;
    o_seen = '0;
    for (int i = 0; i < n; i++) begin
      s_seen[i] = sort_err;
      o_seen[i] = ovf_err;
      inA = (ia < 8) ? a_arr[ia & 7] : 32'hFFFF_FFFF;
      inB = (ib < 8) ? b_arr[ib & 7] : 32'hFFFF_FFFF;
      start_in = start_mask[i];
      #1;
      c_seen[i] = ctrl_addr_out;
      if (ctrl_addr_out) ib++;
      else               ia++;
      @(negedge clk);
    end
    start_in = 1'b0;
    s_seen[n] = sort_err;
    o_seen[n] = ovf_err;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %0b expected 0", out_last); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (sort_err !== 1'b0 || ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_errors: got sort=%0b ovf=%0b expected 0 0", sort_err, ovf_err); end
    n_checks++; if (ctrl_addr_out !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got %0b expected 0 with inA>inB", ctrl_addr_out); end
    rst = 1'b0;
    @(negedge clk);
    $display("reset: outputs checked");
  endtask

  task automatic test_basic();
    logic [WW:0] exp_w;
    got_q.delete();
    out_ready = 1'b1;
    set_interleave(0);
    do_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_stream: got %0b expected 1", busy); end
    do_stream(16, 16'h0000, ctrl_seen, serr_seen, ovf_seen);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %0b expected 0", busy); end
    n_checks++; if (ctrl_seen !== 16'hAAAA) begin n_fail++; $display("FAIL basic_ctrl: got %h expected aaaa", ctrl_seen); end
    repeat (4) @(negedge clk);
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d words expected 4", got_q.size()); end
    for (int k = 0; k < 4; k++) begin
      exp_w = {(k == 3), pack4(4*k+1, 4*k+2, 4*k+3, 4*k+4)};
      if (k < got_q.size()) begin
        n_checks++;
        if (got_q[k] !== exp_w) begin n_fail++; $display("FAIL basic_word%0d: got %h expected %h", k, got_q[k], exp_w); end
        else $display("basic word %0d: data=%h last=%0b", k, got_q[k][WW-1:0], got_q[k][WW]);
      end
    end
    n_checks++; if (sort_err !== 1'b0 || ovf_err !== 1'b0) begin n_fail++; $display("FAIL basic_errors: got sort=%0b ovf=%0b expected 0 0", sort_err, ovf_err); end
  endtask

  task automatic test_exhaustion();
    logic [WW:0] exp_w;
    got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_arr[i] = DW'(i + 1);
      b_arr[i] = DW'(i + 9);
    end
    do_start();
    do_stream(16, 16'h0000, ctrl_seen, serr_seen, ovf_seen);
    n_checks++; if (ctrl_seen !== 16'hFF00) begin n_fail++; $display("FAIL exhaust_ctrl: got %h expected ff00", ctrl_seen); end
    repeat (4) @(negedge clk);
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL exhaust_count: got %0d words expected 4", got_q.size()); end
    for (int k = 0; k < 4; k++) begin
      exp_w = {(k == 3), pack4(4*k+1, 4*k+2, 4*k+3, 4*k+4)};
      if (k < got_q.size()) begin
        n_checks++;
        if (got_q[k] !== exp_w) begin n_fail++; $display("FAIL exhaust_word%0d: got %h expected %h", k, got_q[k], exp_w); end
        else $display("exhaust word %0d: data=%h last=%0b", k, got_q[k][WW-1:0], got_q[k][WW]);
      end
    end
    n_checks++; if (sort_err !== 1'b0) begin n_fail++; $display("FAIL exhaust_sort_err: got %0b expected 0", sort_err); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL exhaust_drained: got out_valid=%0b expected 0", out_valid); end
  endtask

  task automatic test_sort_violation();
    logic [WW:0] exp_w [4];
    got_q.delete();
    out_ready = 1'b1;
    a_arr = '{32'd1, 32'd2, 32'd10, 32'd4, 32'd11, 32'd12, 32'd13, 32'd14};
    for (int i = 0; i < 8; i++) b_arr[i] = DW'(20 + i);
    exp_w[0] = {1'b0, pack4(1, 2, 10, 4)};
    exp_w[1] = {1'b0, pack4(11, 12, 13, 14)};
    exp_w[2] = {1'b0, pack4(20, 21, 22, 23)};
    exp_w[3] = {1'b1, pack4(24, 25, 26, 27)};
    do_start();
    do_stream(16, 16'h0000, ctrl_seen, serr_seen, ovf_seen);
    n_checks++; if (serr_seen[3] !== 1'b0) begin n_fail++; $display("FAIL sort_before_4: got %0b expected 0", serr_seen[3]); end
    n_checks++; if (serr_seen[4] !== 1'b1) begin n_fail++; $display("FAIL sort_after_4: got %0b expected 1", serr_seen[4]); end
    repeat (4) @(negedge clk);
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL sort_count: got %0d words expected 4", got_q.size()); end
    for (int k = 0; k < 4; k++) begin
      if (k < got_q.size()) begin
        n_checks++;
        if (got_q[k] !== exp_w[k]) begin n_fail++; $display("FAIL sort_word%0d: got %h expected %h", k, got_q[k], exp_w[k]); end
        else $display("sort word %0d: data=%h last=%0b", k, got_q[k][WW-1:0], got_q[k][WW]);
      end
    end
    // A clean following sequence must not clear the sticky flag.
    set_interleave(100);
    do_start();
    do_stream(16, 16'h0000, ctrl_seen, serr_seen, ovf_seen);
    n_checks++; if (serr_seen !== 17'h1FFFF) begin n_fail++; $display("FAIL sort_sticky: got %h expected 1ffff", serr_seen); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [WW:0] exp_w;
    got_q.delete();
    out_ready = 1'b0;
    set_interleave(0);
    do_start();
    do_stream(16, 16'h0000, ctrl_seen, serr_seen, ovf_seen);
    set_interleave(16);
    do_start();
    do_stream(16, 16'h0000, ctrl_seen, serr_seen, ovf_seen);
    repeat (2) @(negedge clk);
    n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL bp_ovf_at_full: got %0b expected 0", ovf_err); end
    set_interleave(32);
    do_start();
    do_stream(16, 16'h0000, ctrl_seen, serr_seen, ovf_seen);
    repeat (2) @(negedge clk);
    n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL bp_ovf: got %0b expected 1", ovf_err); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== pack4(1, 2, 3, 4)) begin n_fail++; $display("FAIL bp_head: got valid=%0b data=%h expected 1 %h", out_valid, out_data, pack4(1, 2, 3, 4)); end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL bp_no_pop: got %0d words expected 0", got_q.size()); end
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++; if (got_q.size() != 8) begin n_fail++; $display("FAIL bp_count: got %0d words expected 8", got_q.size()); end
    for (int k = 0; k < 8; k++) begin
      exp_w = {(k == 3 || k == 7), pack4(4*k+1, 4*k+2, 4*k+3, 4*k+4)};
      if (k < got_q.size()) begin
        n_checks++;
        if (got_q[k] !== exp_w) begin n_fail++; $display("FAIL bp_word%0d: got %h expected %h", k, got_q[k], exp_w); end
        else $display("backpressure word %0d: data=%h last=%0b", k, got_q[k][WW-1:0], got_q[k][WW]);
      end
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got out_valid=%0b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [WW:0] exp_w;
    pulse_reset();
    got_q.delete();
    out_ready = 1'b1;
    set_interleave(0);
    do_start();
    // Start during the stream sets pending; a second one while pending is lost.
    do_stream(16, 16'h0220, ctrl_seen, serr_seen, ovf_seen);
    n_checks++; if (ovf_seen[9] !== 1'b0) begin n_fail++; $display("FAIL b2b_first_start_ovf: got %0b expected 0", ovf_seen[9]); end
    n_checks++; if (ovf_seen[10] !== 1'b1) begin n_fail++; $display("FAIL b2b_third_start_ovf: got %0b expected 1", ovf_seen[10]); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_pending: got %0b expected 1", busy); end
    // Second sequence opens with inA > inB, so the select exposes STREAM entry.
    for (int i = 0; i < 8; i++) begin
      a_arr[i] = DW'(16 + 2*i + 2);
      b_arr[i] = DW'(16 + 2*i + 1);
    end
    inA = a_arr[0];
    inB = b_arr[0];
    #1;
    n_checks++; if (ctrl_addr_out !== 1'b0) begin n_fail++; $display("FAIL b2b_wait0_ctrl: got %0b expected 0", ctrl_addr_out); end
    @(negedge clk);
    #1;
    n_checks++; if (ctrl_addr_out !== 1'b0) begin n_fail++; $display("FAIL b2b_wait1_ctrl: got %0b expected 0", ctrl_addr_out); end
    @(negedge clk);
    do_stream(16, 16'h0000, ctrl_seen, serr_seen, ovf_seen);
    n_checks++; if (ctrl_seen !== 16'h5555) begin n_fail++; $display("FAIL b2b_ctrl: got %h expected 5555", ctrl_seen); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_fall: got %0b expected 0", busy); end
    repeat (4) @(negedge clk);
    n_checks++; if (got_q.size() != 8) begin n_fail++; $display("FAIL b2b_count: got %0d words expected 8", got_q.size()); end
    for (int k = 0; k < 8; k++) begin
      exp_w = {(k == 3 || k == 7), pack4(4*k+1, 4*k+2, 4*k+3, 4*k+4)};
      if (k < got_q.size()) begin
        n_checks++;
        if (got_q[k] !== exp_w) begin n_fail++; $display("FAIL b2b_word%0d: got %h expected %h", k, got_q[k], exp_w); end
        else $display("back_to_back word %0d: data=%h last=%0b", k, got_q[k][WW-1:0], got_q[k][WW]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [WW:0] exp_w;
    got_q.delete();
    out_ready = 1'b0;
    set_interleave(0);
    do_start();
    do_stream(6, 16'h0000, ctrl_seen, serr_seen, ovf_seen);
    n_checks++; if (out_valid !== 1'b1 || ovf_err !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got valid=%0b ovf=%0b expected 1 1", out_valid, ovf_err); end
    inA = 32'd9;
    inB = 32'd2;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL midrst_fifo: got valid=%0b data=%h expected 0 0", out_valid, out_data); end
    n_checks++; if (busy !== 1'b0 || ctrl_addr_out !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got busy=%0b ctrl=%0b expected 0 0", busy, ctrl_addr_out); end
    n_checks++; if (ovf_err !== 1'b0 || sort_err !== 1'b0) begin n_fail++; $display("FAIL midrst_errors: got sort=%0b ovf=%0b expected 0 0", sort_err, ovf_err); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    set_interleave(200);
    do_start();
    do_stream(16, 16'h0000, ctrl_seen, serr_seen, ovf_seen);
    repeat (4) @(negedge clk);
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL midrst_count: got %0d words expected 4", got_q.size()); end
    for (int k = 0; k < 4; k++) begin
      exp_w = {(k == 3), pack4(200+4*k+1, 200+4*k+2, 200+4*k+3, 200+4*k+4)};
      if (k < got_q.size()) begin
        n_checks++;
        if (got_q[k] !== exp_w) begin n_fail++; $display("FAIL midrst_word%0d: got %h expected %h", k, got_q[k], exp_w); end
        else $display("mid_reset word %0d: data=%h last=%0b", k, got_q[k][WW-1:0], got_q[k][WW]);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    start_in  = 1'b0;
    out_ready = 1'b0;
    inA       = 32'd5;
    inB       = 32'd3;
    test_reset();
    test_basic();
    test_exhaustion();
    test_sort_violation();
    pulse_reset();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
